// File: rtl/wb_conmax_pkg.sv
// Shared definitions for the Wishbone slave-side arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package wb_conmax_pkg;

    localparam int NUM_MASTERS_DEF = 8;
    localparam int PRIO_BITS_DEF   = 2;
    localparam int TIMEOUT_DEF     = 256;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Masked circular priority encoder: among requesters at the highest priority,
// picks the first one found scanning upward from last_idx+1 with wraparound.
// Latency: purely combinational. Backpressure: none, the result is always valid.
//
// Ports:
//   req      per-master request bits
//   prio     per-master priority, field m at [m*PRIO_BITS +: PRIO_BITS], higher wins
//   last_idx index of the previous winner; the scan starts just after it
//   idx      winning master index (0 when found=0)
//   found    at least one master is requesting
module wb_rr_pick #(
    parameter int NUM_MASTERS = 8,
    parameter int PRIO_BITS   = 2,
    localparam int IW         = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0]           req,
    input  logic [NUM_MASTERS*PRIO_BITS-1:0] prio,
    input  logic [IW-1:0]                    last_idx,
    output logic [IW-1:0]                    idx,
    output logic                             found
);

    logic [PRIO_BITS-1:0]   max_prio;
    logic [NUM_MASTERS-1:0] elig;
    int                     pos;
    logic                   hit;

    // Highest priority value present among the current requesters.
    always_comb begin
        max_prio = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (req[m] && (prio[m*PRIO_BITS +: PRIO_BITS] > max_prio)) begin
                max_prio = prio[m*PRIO_BITS +: PRIO_BITS];
            end
        end
    end

    // Only requesters sitting at that top priority take part in the rotation.
    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            elig[m] = req[m] && (prio[m*PRIO_BITS +: PRIO_BITS] == max_prio);
        end
    end

    // Visit last_idx+1, last_idx+2, ... last_idx+NUM_MASTERS (mod NUM_MASTERS);
    // the previous winner is therefore examined last.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        pos = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            pos = int'(last_idx) + k;
            if (pos >= NUM_MASTERS) begin
                pos = pos - NUM_MASTERS;
            end
            if (!hit && elig[IW'(pos)]) begin
                idx = IW'(pos);
                hit = 1'b1;
            end
        end
    end

    assign found = |req;

endmodule

// File: rtl/wb_slv_arb.sv
// Per-slave Wishbone arbiter: priority + round-robin grant with ack-less timeout pulse.
// Latency: grant visible 1 cycle after the request is sampled; timeout_o is same-cycle vs ack_i.
// Backpressure: the grant is held (no preemption) until the owner drops its request.
//
// Ports:
//   clk_i, rst_i  rising-edge clock, synchronous active-high reset
//   req_i         per-master CYC decoded to this slave
//   prio_i        per-master priority fields, sampled only when arbitrating
//   ack_i         slave ACK/ERR/RTY, restarts the wait counter
//   gnt_o         one-hot grant; gnt_idx_o its binary index; gnt_vld_o grant active
//   timeout_o     one-cycle pulse after TIMEOUT ack-less cycles (grant is kept)
module wb_slv_arb
    import wb_conmax_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int PRIO_BITS   = PRIO_BITS_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_MASTERS-1:0]           req_i,
    input  logic [NUM_MASTERS*PRIO_BITS-1:0] prio_i,
    input  logic                             ack_i,
    output logic [NUM_MASTERS-1:0]           gnt_o,
    output logic [$clog2(NUM_MASTERS)-1:0]   gnt_idx_o,
    output logic                             gnt_vld_o,
    output logic                             timeout_o
);

    localparam int IW = $clog2(NUM_MASTERS);
    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    arb_state_e    state_q, state_d;
    // idx_q doubles as last_idx: it always holds the most recent winner,
    // which while BUSY is also the current owner.
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          held;
    logic          new_grant;
    logic          timeout_hit;

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .PRIO_BITS   (PRIO_BITS)
    ) u_pick (
        .req      (req_i),
        .prio     (prio_i),
        .last_idx (idx_q),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    // Owner still wants the bus. When it has dropped, its req bit is 0, so the
    // picker naturally excludes it from the same-cycle re-arbitration.
    assign held = req_i[idx_q];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d   = BUSY;
                    idx_d     = pick_idx;
                    new_grant = 1'b1;
                end
            end
            BUSY: begin
                if (!held) begin
                    if (pick_found) begin
                        idx_d     = pick_idx;
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // ack_i in the same cycle suppresses the pulse.
        timeout_hit = (TIMEOUT != 0) && (state_q == BUSY) && (cnt_q == CNT_LAST) && !ack_i;

        if ((TIMEOUT == 0) || (state_d != BUSY) || new_grant || ack_i || timeout_hit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= IW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_vld_o = (state_q == BUSY);
    assign gnt_idx_o = gnt_vld_o ? idx_q : '0;
    assign gnt_o     = gnt_vld_o ? ({{(NUM_MASTERS-1){1'b0}}, 1'b1} << idx_q) : '0;
    assign timeout_o = timeout_hit && !rst_i;

endmodule

// File: tb/tb_wb_slv_arb.sv
// Bench for wb_slv_arb: directed scenarios with literal expectations plus a
// cycle-by-cycle comparison against a behavioural arbiter model.
// A second instance with TIMEOUT=0 shares the stimulus.
module tb_wb_slv_arb;

    localparam int N  = 8;
    localparam int PB = 2;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           ack;
    logic [N-1:0]   req;
    logic [N*PB-1:0] prio;

    logic [N-1:0]   gnt,  gnt0;
    logic [2:0]     gidx, gidx0;
    logic           gvld, gvld0;
    logic           tout, tout0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_slv_arb #(.NUM_MASTERS(N), .PRIO_BITS(PB), .TIMEOUT(TO)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .prio_i    (prio),
        .ack_i     (ack),
        .gnt_o     (gnt),
        .gnt_idx_o (gidx),
        .gnt_vld_o (gvld),
        .timeout_o (tout)
    );

    wb_slv_arb #(.NUM_MASTERS(N), .PRIO_BITS(PB), .TIMEOUT(0)) dut_noto (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .prio_i    (prio),
        .ack_i     (ack),
        .gnt_o     (gnt0),
        .gnt_idx_o (gidx0),
        .gnt_vld_o (gvld0),
        .timeout_o (tout0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Winner = highest priority; ties broken by the shortest forward distance
    // from the previous winner (distance 0 means last+1).
    function automatic int model_pick(input logic [N-1:0] r, input logic [N*PB-1:0] p,
                                      input int last);
        int best   = -1;
        int best_p = -1;
        int best_d = N;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                int pv;
                int d;
                pv = int'(p[i*PB +: PB]);
                d  = (i - last - 1 + 2 * N) % N;
                if ((pv > best_p) || ((pv == best_p) && (d < best_d))) begin
                    best   = i;
                    best_p = pv;
                    best_d = d;
                end
            end
        end
        return best;
    endfunction

    bit           m_ok     = 1'b0;
    bit           m_busy   = 1'b0;
    int           m_last   = N - 1;   // current owner while busy, else previous winner
    int           m_waited = 0;       // ack-less owner cycles already completed
    logic [N-1:0] req_at_edge = '0;

    always @(posedge clk) begin
        bit pulse;
        int w;
        pulse       = m_busy && !ack && (m_waited == TO - 1);
        req_at_edge = req;
        if (rst) begin
            m_ok     = 1'b1;
            m_busy   = 1'b0;
            m_last   = N - 1;
            m_waited = 0;
        end else if (m_ok) begin
            if (m_busy && req[m_last]) begin
                m_waited = (ack || pulse) ? 0 : m_waited + 1;
            end else begin
                w = model_pick(req, prio, m_last);
                if (w >= 0) begin
                    m_busy = 1'b1;
                    m_last = w;
                end else begin
                    m_busy = 1'b0;
                end
                m_waited = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_ok) begin
            chk("gnt_vld",  32'(gvld), 32'(m_busy));
            chk("gnt_idx",  32'(gidx), m_busy ? 32'(m_last) : 32'd0);
            chk("gnt",      32'(gnt),  m_busy ? (32'd1 << m_last) : 32'd0);
            chk("timeout",  32'(tout), 32'(m_busy && !rst && !ack && (m_waited == TO - 1)));
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (gvld) begin
                chk("gnt_vs_idx", 32'(gnt), 32'd1 << gidx);
                chk("gnt_owner_req", 32'(req_at_edge[gidx]), 32'd1);
            end
            chk("noto_gnt",     32'(gnt0), m_busy ? (32'd1 << m_last) : 32'd0);
            chk("noto_timeout", 32'(tout0), 32'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [15:0] ack_tab;
    logic [15:0] to_tab;

    initial begin
        rst  = 1'b1;
        req  = '0;
        prio = '0;
        ack  = 1'b0;
        tick(); tick(); tick();
        chk("rst_gnt",     32'(gnt),  32'd0);
        chk("rst_gnt_vld", 32'(gvld), 32'd0);
        chk("rst_gnt_idx", 32'(gidx), 32'd0);
        chk("rst_timeout", 32'(tout), 32'd0);
        rst = 1'b0;

        // Two equal requesters, master 0 first after reset, then master 7.
        req = 8'h81;
        tick();
        chk("t1_first_gnt", 32'(gnt), 32'h01);
        req = 8'h80;
        tick();
        chk("t1_second_idx", 32'(gidx), 32'd7);
        req = 8'h00;
        tick();
        chk("t1_release", 32'(gvld), 32'd0);
        tick();

        // All requesting at prio 2; each owner drops after 3 cycles, then reasserts.
        prio = 16'hAAAA;
        req  = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            chk("t2_rr_idx", 32'(gidx), 32'(k % 8));
            chk("t2_rr_vld", 32'(gvld), 32'd1);
            if (k < 8) begin
                tick();
                tick();
                req[k] = 1'b0;
                tick();
                req[k] = 1'b1;
            end
        end
        chk("t2_wrap_gnt", 32'(gnt), 32'h01);
        req = 8'h00;
        tick(); tick();

        // Priority win, then no preemption when the loser's priority rises.
        prio = 16'h00D0;
        req  = 8'h0C;
        tick();
        chk("t3_prio_win", 32'(gidx), 32'd3);
        prio = 16'h00F0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_no_preempt", 32'(gidx), 32'd3);
        end
        req = 8'h04;
        tick();
        chk("t3_handover", 32'(gidx), 32'd2);
        req = 8'h00;
        tick(); tick();
        prio = '0;

        // Timeout with no ack: pulses on owner cycles 4 and 8.
        req = 8'h02;
        tick();
        chk("t4_owner", 32'(gidx), 32'd1);
        for (int c = 1; c <= 9; c++) begin
            chk("t4_noack_pulse", 32'(tout), 32'((c % 4) == 0));
            tick();
        end
        req = 8'h00;
        tick(); tick();

        // ack on cycle 3 restarts the wait (pulse moves to cycle 7);
        // ack coinciding with the would-be pulse on cycle 11 suppresses it.
        ack_tab = 16'h0808;   // cycles 3 and 11
        to_tab  = 16'h0080;   // cycle 7
        req = 8'h02;
        tick();
        for (int c = 1; c <= 11; c++) begin
            ack = ack_tab[c];
            #1;
            chk("t4_ack_pulse", 32'(tout), 32'(to_tab[c]));
            tick();
        end
        ack = 1'b0;
        req = 8'h00;
        tick(); tick();

        // Reset mid-grant clears the grant and forgets the previous winner.
        req = 8'h21;
        tick();
        chk("t5_owner5", 32'(gidx), 32'd5);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_vld", 32'(gvld), 32'd0);
        chk("t5_rst_gnt", 32'(gnt),  32'd0);
        rst = 1'b0;
        tick();
        chk("t5_after_rst_gnt", 32'(gnt), 32'h01);
        req = 8'h00;
        tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
